// File: rtl/restore_divider_pkg.sv
// ============================================================================
// Module  : restore_divider_pkg
// Brief   : Shared opcode encodings and default width for the restoring divider
// Revision: 1.0
// ============================================================================
`default_nettype none

package restore_divider_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_INIT = 3'b001;
  localparam logic [2:0] OP_LDQ  = 3'b010;
  localparam logic [2:0] OP_LDM  = 3'b011;
  localparam logic [2:0] OP_RUN  = 3'b100;
  localparam logic [2:0] OP_OUTA = 3'b101;
  localparam logic [2:0] OP_OUTQ = 3'b110;
  localparam logic [2:0] OP_PREP = 3'b111;

endpackage

`default_nettype wire

// File: rtl/restore_divider_step.sv
// ============================================================================
// Module  : restore_step
// Brief   : One combinational restoring-division iteration (shift, trial, restore)
// Revision: 1.0
// ============================================================================
`default_nettype none

module restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  // The shifted remainder keeps one extra bit so the sign of the trial
  // subtraction stays exact even if A ever carried its top bit.
  logic [WIDTH+1:0] w_a_shift;
  logic [WIDTH+1:0] w_trial;
  logic [WIDTH-1:0] w_q_shift;

  always_comb begin
    w_a_shift = {i_a, i_q[WIDTH-1]};
    w_q_shift = {i_q[WIDTH-2:0], 1'b0};
    w_trial   = w_a_shift - {2'b00, i_m};
    if (w_trial[WIDTH+1]) begin
      o_a = w_a_shift[WIDTH:0];
      o_q = w_q_shift;
    end else begin
      o_a = w_trial[WIDTH:0];
      o_q = w_q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/restore_divider.sv
// ============================================================================
// Module  : restore_divider
// Brief   : Opcode-sequenced unsigned restoring divider, one quotient bit/clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module restore_divider
  import restore_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inbus,
  input  logic [2:0]       enable,
  output logic [WIDTH-1:0] outbus,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_cnt_full = CW'(WIDTH);

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_a;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;

  restore_step #(.WIDTH(WIDTH)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_next),
    .o_q (w_q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m    <= '0;
      r_q    <= '0;
      r_a    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      case (enable)
        OP_INIT: begin
          r_m    <= '0;
          r_q    <= '0;
          r_a    <= '0;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        OP_LDM: r_m <= inbus;
        OP_LDQ: begin
          r_q    <= inbus;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        OP_PREP: begin
          r_a    <= '0;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
        OP_RUN: begin
          // Once all WIDTH iterations are done, further run cycles hold state.
          if (r_cnt < c_cnt_full) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == c_cnt_last) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    outbus = '0;
    case (enable)
      OP_OUTA: outbus = r_a[WIDTH-1:0];
      OP_OUTQ: outbus = r_q;
      default: outbus = '0;
    endcase
  end

  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_restore_divider.sv
// ============================================================================
// Module  : tb_restore_divider
// Brief   : Self-checking bench for restore_divider against an arithmetic model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_restore_divider;
  import restore_divider_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] inbus;
  logic [2:0]       enable;
  logic [WIDTH-1:0] outbus;
  logic             done;

  int n_cmp;
  int n_err;

  restore_divider #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .inbus  (inbus),
    .enable (enable),
    .outbus (outbus),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; a zero divisor yields all ones / dividend.
  function automatic void ref_div(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
    if (m == 0) begin
      q = '1;
      r = d;
    end else begin
      q = d / m;
      r = d % m;
    end
  endfunction

  task automatic apply(input logic [2:0] op, input logic [WIDTH-1:0] data);
    enable = op;
    inbus  = data;
    @(posedge clk);
    #1;
    enable = OP_NOP;
  endtask

  task automatic peek(input logic [2:0] op, output logic [WIDTH-1:0] val);
    enable = op;
    #1;
    val    = outbus;
    enable = OP_NOP;
  endtask

  task automatic setup(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d);
    apply(OP_INIT, '0);
    apply(OP_LDM, m);
    apply(OP_LDQ, d);
    apply(OP_PREP, '0);
  endtask

  task automatic runs(input int n);
    for (int i = 0; i < n; i++) apply(OP_RUN, '0);
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] v;
    rst = 1'b1;
    apply(OP_NOP, '0);
    apply(OP_NOP, '0);
    rst = 1'b0;
    peek(OP_OUTA, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_a got %h exp 00", v); end
    peek(OP_OUTQ, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_q got %h exp 00", v); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  task automatic check_div(input string name, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] eq, er, vq, va;
    ref_div(m, d, eq, er);
    setup(m, d);
    runs(WIDTH);
    peek(OP_OUTQ, vq);
    peek(OP_OUTA, va);
    n_cmp++; if (vq !== eq) begin n_err++; $display("FAIL %s_q m=%h d=%h got %h exp %h", name, m, d, vq, eq); end
    n_cmp++; if (va !== er) begin n_err++; $display("FAIL %s_a m=%h d=%h got %h exp %h", name, m, d, va, er); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done got %b exp 1", name, done); end
  endtask

  task automatic test_directed();
    check_div("d127_25", 8'd25, 8'd127);
    check_div("d255_1", 8'd1, 8'd255);
    check_div("d7_9", 8'd9, 8'd7);
    check_div("d255_255", 8'd255, 8'd255);
  endtask

  task automatic test_div_zero();
    check_div("divzero", 8'd0, 8'h5A);
  endtask

  task automatic test_pause();
    logic [WIDTH-1:0] vq, va;
    setup(8'd25, 8'd127);
    runs(4);
    for (int i = 0; i < 3; i++) apply(OP_NOP, '0);
    runs(3);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL pause_early_done got %b exp 0", done); end
    runs(1);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL pause_done got %b exp 1", done); end
    peek(OP_OUTQ, vq);
    peek(OP_OUTA, va);
    n_cmp++; if (vq !== 8'd5) begin n_err++; $display("FAIL pause_q got %h exp 05", vq); end
    n_cmp++; if (va !== 8'd2) begin n_err++; $display("FAIL pause_a got %h exp 02", va); end
  endtask

  task automatic test_reset_midrun();
    logic [WIDTH-1:0] v;
    setup(8'd25, 8'd127);
    runs(3);
    rst = 1'b1;
    apply(OP_RUN, '0);
    rst = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b exp 0", done); end
    peek(OP_OUTA, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL midrst_a got %h exp 00", v); end
    peek(OP_OUTQ, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL midrst_q got %h exp 00", v); end
    // M was cleared by reset, so a fresh dividend must divide by zero.
    apply(OP_LDQ, 8'h3C);
    apply(OP_PREP, '0);
    runs(WIDTH);
    peek(OP_OUTQ, v);
    n_cmp++; if (v !== 8'hFF) begin n_err++; $display("FAIL midrst_m_q got %h exp ff", v); end
    peek(OP_OUTA, v);
    n_cmp++; if (v !== 8'h3C) begin n_err++; $display("FAIL midrst_m_a got %h exp 3c", v); end
  endtask

  task automatic test_after_done();
    logic [WIDTH-1:0] v;
    setup(8'd13, 8'd200);
    runs(WIDTH + 3);
    peek(OP_OUTQ, v);
    n_cmp++; if (v !== 8'd15) begin n_err++; $display("FAIL extra_q got %h exp 0f", v); end
    peek(OP_OUTA, v);
    n_cmp++; if (v !== 8'd5) begin n_err++; $display("FAIL extra_a got %h exp 05", v); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL extra_done got %b exp 1", done); end
    peek(OP_NOP, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL out_nop got %h exp 00", v); end
    peek(OP_LDM, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL out_ldm got %h exp 00", v); end
    peek(OP_LDQ, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL out_ldq got %h exp 00", v); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] m, d;
    for (int i = 0; i < 30; i++) begin
      m = WIDTH'($urandom_range(0, 255));
      d = WIDTH'($urandom_range(0, 255));
      if (i % 5 == 0) m = WIDTH'($urandom_range(0, 3));
      check_div("rand", m, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] eq, er, vq, va, m, d;
    // Reload only the dividend and prepare again, keeping M from the previous run.
    setup(8'd7, 8'd100);
    runs(WIDTH);
    for (int i = 0; i < 5; i++) begin
      m = 8'd7;
      d = WIDTH'($urandom_range(0, 255));
      ref_div(m, d, eq, er);
      apply(OP_LDQ, d);
      apply(OP_PREP, '0);
      runs(WIDTH);
      peek(OP_OUTQ, vq);
      peek(OP_OUTA, va);
      n_cmp++; if (vq !== eq) begin n_err++; $display("FAIL b2b_q d=%h got %h exp %h", d, vq, eq); end
      n_cmp++; if (va !== er) begin n_err++; $display("FAIL b2b_a d=%h got %h exp %h", d, va, er); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b0;
    inbus  = '0;
    enable = OP_NOP;
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_pause();
    test_reset_midrun();
    test_after_done();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/restore_divider.md
Name: restore_divider

Overview:
- Sequential unsigned restoring divider with a shared 8-bit input bus and an 8-bit output bus.
- A 3-bit opcode on `enable` sequences it:
  - load divisor M and dividend Q
  - run one quotient bit per clock
  - place remainder A or quotient Q on `outbus`
- Used as a datapath slave under an external controller or bench that drives opcodes.

Parameters:
- WIDTH, 8, operand width of M, Q, A[WIDTH-1:0], inbus and outbus.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- inbus  input  WIDTH  operand input, sampled on load opcodes
- enable  input  3  opcode (see Behaviour)
- outbus  output  WIDTH  selected result, combinational from registers
- done  output  1  high once WIDTH iterations have completed

Behaviour:
- Registers:
  - M: WIDTH bits
  - Q: WIDTH bits
  - A: WIDTH+1 bits, signed partial remainder
  - cnt: clog2(WIDTH+1) bits
  - done
- rst (sync) or opcode 001 (init): A, Q, M, cnt, done all cleared to 0. rst has priority over every opcode.
- Opcodes, applied at the clk edge:
  - 000: no-op, hold all.
  - 001: init, as above.
  - 011: M <= inbus.
  - 010: Q <= inbus; cnt <= 0; done <= 0.
  - 111: prepare; A <= 0; cnt <= 0; done <= 0; M and Q held.
  - 100: run; if cnt < WIDTH, perform one iteration and cnt <= cnt+1; done <= 1 when cnt reaches WIDTH. If cnt == WIDTH, hold all.
  - 101: output A. No register change.
  - 110: output Q. No register change.
- Iteration, single cycle, combinational step:
  1. {A,Q} shifted left 1.
  2. T = A_shifted - {1'b0,M}.
  3. If T[WIDTH] == 1 (negative): A <= A_shifted (restore) and Q[0] <= 0.
  4. Else: A <= T and Q[0] <= 1.
- Latency: exactly WIDTH clocks of opcode 100 after prepare. Then Q = floor(dividend/M) and A[WIDTH-1:0] = dividend mod M.
- Pausing: leaving 100 mid-run freezes A, Q and cnt. Resuming 100 continues from the frozen cnt with an identical final result.
- outbus:
  - A[WIDTH-1:0] when enable == 101.
  - Q when enable == 110.
  - 0 for all other opcodes and after reset.
- Divide by zero (M = 0): no error flag. The result is Q = all ones and A[WIDTH-1:0] = the original dividend.
- Loading M or Q during run is permitted and takes effect on the next iteration. The result is then undefined; the bench must not rely on it.
- Reset mid-run aborts: all registers 0, done 0, outbus 0.

Decomposition:
- Shared package holds:
  - the opcode localparams: OP_NOP=000, OP_INIT=001, OP_LDQ=010, OP_LDM=011, OP_RUN=100, OP_OUTA=101, OP_OUTQ=110, OP_PREP=111
  - the default WIDTH
- One natural sub-module, restore_step: combinational single iteration with inputs A, Q, M and outputs next A, next Q.

Test Plan:
- init, M=25 (0x19), Q=127 (0x7F), prepare, 8 clocks of run -> done=1; enable 101 gives outbus=2; enable 110 gives outbus=5.
- M=1, Q=255 -> Q=255, A=0; M=9, Q=7 -> Q=0, A=7; M=255, Q=255 -> Q=1, A=0.
- M=0, Q=0x5A, run 8 -> outbus(110)=0xFF, outbus(101)=0x5A, done=1.
- 127/25 with run deasserted (000) for 3 cycles after iteration 4 -> same result Q=5, A=2, done asserted only after 8 run cycles total.
- rst asserted at iteration 3 -> next cycle A=Q=M=0, done=0, outbus=0 for opcodes 101 and 110.
- Extra run cycles after done -> Q, A unchanged. Opcodes 000/011/010 -> outbus=0.
